// File: rtl/test_tx_pkg.sv
// Shared definitions for the MAC TX test-frame generator: payload modes, FSM states
// and the scrambler used for the pseudo-random payload modes.
package test_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_LFSR_SEED = 2'd0;
  localparam logic [1:0] MODE_LFSR_FREE = 2'd1;
  localparam logic [1:0] MODE_CNT       = 2'd2;
  localparam logic [1:0] MODE_ALT       = 2'd3;

  // Fibonacci taps for x^16+x^15+x^13+x^4+1; bit 15 is the oldest bit and the output bit.
  localparam logic [15:0] SCR_POLY = 16'hD008;

  // Advance the scrambler 32 bit-times; returns {next_state, output_word} with bit 0 first out.
  function automatic logic [47:0] scr_step32(input logic [15:0] state);
    logic [15:0] st;
    logic [31:0] word;
    st   = state;
    word = 32'd0;
    for (int i = 0; i < 32; i++) begin
      word[i] = st[15];
      st      = {st[14:0], ^(st & SCR_POLY)};
    end
    return {st, word};
  endfunction

endpackage

// File: rtl/test_tx_gen_if.sv
// Byte-stream link from the test-frame generator to the MAC TX input.
interface test_tx_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sof;
  logic              eof;
  logic              ready;

  modport master (output data, valid, sof, eof, input ready);
  modport slave  (input data, valid, sof, eof, output ready);
endinterface

// File: rtl/test_tx_lfsr.sv
// 16-bit payload scrambler; presents one 32-bit word per state and advances on en.
// reseed has priority so a new frame can restart from the seed on the same edge.
module test_tx_lfsr
  import test_tx_pkg::*;
#(
  parameter logic [15:0] LFSR_INIT = 16'h55AA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        reseed,
  output logic [31:0] dout
);
  logic [15:0] state_q, state_d;
  logic [47:0] step;

  assign step = scr_step32(state_q);
  assign dout = step[31:0];

  // Next scrambler state
  always_comb begin
    state_d = state_q;
    if (reseed) begin
      state_d = LFSR_INIT;
    end else if (en) begin
      state_d = step[47:32];
    end else begin
      state_d = state_q;
    end
  end

  // Scrambler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_INIT;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/test_tx_gen.sv
// Test-frame generator: back-to-back frames of configurable length, gap and count on the
// MAC TX byte stream, with scrambled, counting or alternating payload.
module test_tx_gen
  import test_tx_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          LEN_W     = 16,
  parameter int          GAP_W     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_INIT = 16'h55AA
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [1:0]       cfg_mode,
  test_tx_gen_if.master    mac_tx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_num
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] last_q, last_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [1:0]       mode_q, mode_d;
  logic             stop_pend_q, stop_pend_d;

  logic             valid;
  logic             accept;
  logic             eof_beat;
  logic             last_frame;
  logic             reseed;
  logic [31:0]      lfsr_out;
  logic [31:0]      pattern;
  logic             unused_bits;

  assign valid      = (state_q == ST_DATA);
  assign accept     = valid & mac_tx.ready;
  assign eof_beat   = (beat_q == last_q);
  // A stop arriving on the eof beat itself still ends the run after that frame.
  assign last_frame = ((count_q != '0) && ((frame_q + CNT_W'(1)) == count_q))
                      || stop_pend_q || stop;

  test_tx_lfsr #(
    .LFSR_INIT (LFSR_INIT)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (accept),
    .reseed (reseed),
    .dout   (lfsr_out)
  );

  // State and run-context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      last_q      <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      count_q     <= '0;
      frame_q     <= '0;
      mode_q      <= MODE_LFSR_SEED;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next-state and run-context update
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_d      = last_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    count_d     = count_q;
    frame_d     = frame_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;
    reseed      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_DATA;
          last_d      = (cfg_len == '0) ? '0 : (cfg_len - LEN_W'(1));
          gap_d       = cfg_gap;
          count_d     = cfg_count;
          mode_d      = cfg_mode;
          frame_d     = '0;
          beat_d      = '0;
          stop_pend_d = 1'b0;
          reseed      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        stop_pend_d = stop_pend_q | stop;
        if (accept && eof_beat) begin
          beat_d  = '0;
          frame_d = frame_q + CNT_W'(1);
          if (last_frame) begin
            state_d = ST_FIN;
          end else if (gap_q != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q - GAP_W'(1);
          end else begin
            state_d = ST_DATA;
            reseed  = (mode_q == MODE_LFSR_SEED);
          end
        end else if (accept) begin
          beat_d = beat_q + LEN_W'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_FIN;
        end else if (gap_cnt_q == '0) begin
          state_d = ST_DATA;
          reseed  = (mode_q == MODE_LFSR_SEED);
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stream and status outputs, all decoded from registered state
  always_comb begin
    pattern = 32'd0;
    case (mode_q)
      MODE_LFSR_SEED: pattern = lfsr_out;
      MODE_LFSR_FREE: pattern = lfsr_out;
      MODE_CNT:       pattern = 32'(beat_q);
      MODE_ALT:       pattern = beat_q[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      default:        pattern = 32'd0;
    endcase
    mac_tx.valid = valid;
    mac_tx.sof   = valid & (beat_q == '0);
    mac_tx.eof   = valid & eof_beat;
    mac_tx.data  = valid ? pattern[DATA_W-1:0] : '0;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_FIN);
    frame_num    = frame_q;
  end

  assign unused_bits = ^pattern;

endmodule
